// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA video-RAM path.
// 256x256 frame of 3-bit {R,G,B} pixels.
package vga_pkg;

  localparam int ADDR_W  = 16;
  localparam int COLOR_W = 3;
  localparam int RES_H   = 256;
  localparam int RES_V   = 256;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_RD,
    SLOT_WR
  } slot_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/vram_write_fifo.sv
// Synchronous FIFO buffering CPU pixel writes.
// Full/empty are decoded from the occupancy count.
module vram_write_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: pixel reads win every cycle,
// queued CPU writes drain into otherwise idle RAM slots.
module vga_vram_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int COLOR_W     = 3,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iPixelReq,
  input  logic [ADDR_W-1:0]  iPixelAddr,
  output logic [COLOR_W-1:0] oPixelColor,
  output logic               oPixelValid,
  input  logic               iWrReq,
  input  logic [ADDR_W-1:0]  iWrAddr,
  input  logic [COLOR_W-1:0] iWrData,
  output logic               oWrAck,
  output logic               oWrFull,
  output logic               oWrOverflow,
  output logic [ADDR_W-1:0]  oRamAddr,
  output logic               oRamWrEn,
  output logic [COLOR_W-1:0] oRamWrData,
  input  logic [COLOR_W-1:0] iRamRdData
);

  import vga_pkg::*;

  localparam int EW = ADDR_W + COLOR_W;

  slot_e         slot_q;
  slot_e         slot_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic          rd_p1;

  assign push    = iWrReq & ~fifo_full;
  assign pop     = (slot_d == SLOT_WR);
  assign oWrAck  = push;
  assign oWrFull = fifo_full;

  vram_write_fifo #(
    .W     (EW),
    .DEPTH (WFIFO_DEPTH)
  ) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .wdata ({iWrAddr, iWrData}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    slot_d = SLOT_IDLE;
    priority case (1'b1)
      iPixelReq:   slot_d = SLOT_RD;
      !fifo_empty: slot_d = SLOT_WR;
      default:     slot_d = SLOT_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      slot_q      <= SLOT_IDLE;
      oRamAddr    <= '0;
      oRamWrEn    <= 1'b0;
      oRamWrData  <= '0;
      rd_p1       <= 1'b0;
      oPixelValid <= 1'b0;
      oPixelColor <= '0;
      oWrOverflow <= 1'b0;
    end else begin
      slot_q <= slot_d;
      unique case (slot_d)
        SLOT_RD: begin
          oRamAddr <= iPixelAddr;
          oRamWrEn <= 1'b0;
        end
        SLOT_WR: begin
          oRamAddr   <= head[EW-1:COLOR_W];
          oRamWrData <= head[COLOR_W-1:0];
          oRamWrEn   <= 1'b1;
        end
        default: oRamWrEn <= 1'b0;
      endcase
      // RAM data for a read slot lands one cycle after the slot
      rd_p1       <= (slot_q == SLOT_RD);
      oPixelValid <= rd_p1;
      if (rd_p1) oPixelColor <= iRamRdData;
      if (iWrReq & fifo_full) oWrOverflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter with a behavioural
// synchronous RAM preloaded so that mem[a] = a[2:0].
module tb_vga_vram_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iPixelReq = 1'b0;
  logic [15:0] iPixelAddr = '0;
  logic [2:0]  oPixelColor;
  logic        oPixelValid;
  logic        iWrReq = 1'b0;
  logic [15:0] iWrAddr = '0;
  logic [2:0]  iWrData = '0;
  logic        oWrAck;
  logic        oWrFull;
  logic        oWrOverflow;
  logic [15:0] oRamAddr;
  logic        oRamWrEn;
  logic [2:0]  oRamWrData;
  bit   [2:0]  ram_rd;

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  vga_vram_arbiter #(
    .ADDR_W      (16),
    .COLOR_W     (3),
    .WFIFO_DEPTH (4)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iPixelReq   (iPixelReq),
    .iPixelAddr  (iPixelAddr),
    .oPixelColor (oPixelColor),
    .oPixelValid (oPixelValid),
    .iWrReq      (iWrReq),
    .iWrAddr     (iWrAddr),
    .iWrData     (iWrData),
    .oWrAck      (oWrAck),
    .oWrFull     (oWrFull),
    .oWrOverflow (oWrOverflow),
    .oRamAddr    (oRamAddr),
    .oRamWrEn    (oRamWrEn),
    .oRamWrData  (oRamWrData),
    .iRamRdData  (ram_rd)
  );

  // RAM model: unwritten locations read back addr[2:0]
  bit [2:0] mem  [65536];
  bit       seen [65536];

  always @(posedge Clock) begin
    ram_rd <= seen[oRamAddr] ? mem[oRamAddr] : oRamAddr[2:0];
    if (oRamWrEn) begin
      mem[oRamAddr]  <= oRamWrData;
      seen[oRamAddr] <= 1'b1;
    end
  end

  typedef struct {
    bit        req;
    bit [15:0] pa;
    bit        wr;
    bit [15:0] wa;
    bit [2:0]  wd;
    bit        ack;
    bit        vld;
    bit        cc;
    bit [2:0]  col;
    bit        we;
    bit        ca;
    bit [15:0] ea;
    bit [2:0]  ed;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input bit req, input bit [15:0] pa,
                       input bit wr, input bit [15:0] wa,
                       input bit [2:0] wd);
    iPixelReq  = req;
    iPixelAddr = pa;
    iWrReq     = wr;
    iWrAddr    = wa;
    iWrData    = wd;
  endtask

  task automatic chk_wr(input string nm, input bit [15:0] a,
                        input bit [2:0] d);
    chk({nm, "_wren"}, 32'(oRamWrEn), 32'(1));
    chk({nm, "_addr"}, 32'(oRamAddr), 32'(a));
    chk({nm, "_data"}, 32'(oRamWrData), 32'(d));
  endtask

  initial begin
    tv[0]  = '{req:1, pa:16'h0, ca:1, ea:16'h0, default:0};
    tv[1]  = '{req:1, pa:16'h1, ca:1, ea:16'h1, default:0};
    tv[2]  = '{req:1, pa:16'h2, vld:1, cc:1, col:0,
               ca:1, ea:16'h2, default:0};
    tv[3]  = '{req:1, pa:16'h3, vld:1, cc:1, col:1,
               ca:1, ea:16'h3, default:0};
    tv[4]  = '{vld:1, cc:1, col:2, ca:1, ea:16'h3,
               default:0};
    tv[5]  = '{vld:1, cc:1, col:3, default:0};
    tv[6]  = '{cc:1, col:3, default:0};
    tv[7]  = '{wr:1, wa:16'h1234, wd:5, ack:1, ca:1,
               ea:16'h3, default:0};
    tv[8]  = '{we:1, ea:16'h1234, ed:5, default:0};
    tv[9]  = '{ca:1, ea:16'h1234, default:0};
    tv[10] = '{req:1, pa:16'h1234, ca:1, ea:16'h1234,
               default:0};
    tv[11] = '{default:0};
    tv[12] = '{vld:1, cc:1, col:5, default:0};

    // reset state
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_valid", 32'(oPixelValid), 0);
    chk("rst_color", 32'(oPixelColor), 0);
    chk("rst_addr", 32'(oRamAddr), 0);
    chk("rst_wren", 32'(oRamWrEn), 0);
    chk("rst_wdata", 32'(oRamWrData), 0);
    chk("rst_ovf", 32'(oWrOverflow), 0);
    chk("rst_full", 32'(oWrFull), 0);
    Reset = 1'b1;

    // reads, single write, readback of the written pixel
    for (int i = 0; i < 13; i++) begin
      drive(tv[i].req, tv[i].pa, tv[i].wr,
            tv[i].wa, tv[i].wd);
      #1;
      chk($sformatf("tv%0d_ack", i), 32'(oWrAck),
          32'(tv[i].ack));
      step();
      chk($sformatf("tv%0d_valid", i), 32'(oPixelValid),
          32'(tv[i].vld));
      if (tv[i].cc)
        chk($sformatf("tv%0d_color", i), 32'(oPixelColor),
            32'(tv[i].col));
      chk($sformatf("tv%0d_wren", i), 32'(oRamWrEn),
          32'(tv[i].we));
      if (tv[i].we || tv[i].ca)
        chk($sformatf("tv%0d_addr", i), 32'(oRamAddr),
            32'(tv[i].ea));
      if (tv[i].we)
        chk($sformatf("tv%0d_wdata", i), 32'(oRamWrData),
            32'(tv[i].ed));
      chk($sformatf("tv%0d_full", i), 32'(oWrFull), 0);
    end

    // fill under reads, then push+pop while full
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'h0, 1, 16'h2000 + 16'(i), 3'(i + 1));
      #1;
      chk("fill_ack", 32'(oWrAck), 1);
      step();
      chk("fill_wren", 32'(oRamWrEn), 0);
    end
    chk("fill_full", 32'(oWrFull), 1);
    chk("fill_ovf", 32'(oWrOverflow), 0);
    drive(0, 16'h0, 1, 16'h2fff, 3'd7);
    #1;
    chk("fullpp_ack", 32'(oWrAck), 0);
    step();
    chk_wr("fullpp_w0", 16'h2000, 3'd1);
    chk("fullpp_full", 32'(oWrFull), 0);
    chk("fullpp_ovf", 32'(oWrOverflow), 1);
    drive(0, 16'h0, 0, 16'h0, 3'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_wr($sformatf("fullpp_w%0d", i),
             16'h2000 + 16'(i), 3'(i + 1));
    end
    step();
    chk("fullpp_idle", 32'(oRamWrEn), 0);

    // interleave reads and writes
    drive(1, 16'h5, 1, 16'h3000, 3'd2);
    #1;
    chk("il_ack0", 32'(oWrAck), 1);
    step();
    drive(1, 16'h6, 1, 16'h3001, 3'd3);
    #1;
    chk("il_ack1", 32'(oWrAck), 1);
    step();
    begin
      bit        preq [6] = '{1, 0, 1, 0, 0, 0};
      bit [15:0] padr [6] = '{16'h7, 0, 16'h4, 0, 0, 0};
      bit        ewe  [6] = '{0, 1, 0, 1, 0, 0};
      bit [15:0] eadr [6] = '{16'h7, 16'h3000, 16'h4,
                             16'h3001, 0, 0};
      bit [2:0]  edat [6] = '{0, 2, 0, 3, 0, 0};
      bit        evld [6] = '{1, 1, 1, 0, 1, 0};
      bit [2:0]  ecol [6] = '{5, 6, 7, 0, 4, 0};
      for (int i = 0; i < 6; i++) begin
        drive(preq[i], padr[i], 0, 16'h0, 3'd0);
        step();
        chk($sformatf("il%0d_wren", i), 32'(oRamWrEn),
            32'(ewe[i]));
        if (i < 4)
          chk($sformatf("il%0d_addr", i), 32'(oRamAddr),
              32'(eadr[i]));
        if (ewe[i])
          chk($sformatf("il%0d_wdata", i), 32'(oRamWrData),
              32'(edat[i]));
        chk($sformatf("il%0d_valid", i), 32'(oPixelValid),
            32'(evld[i]));
        if (evld[i])
          chk($sformatf("il%0d_color", i), 32'(oPixelColor),
              32'(ecol[i]));
      end
    end

    // async reset with queued writes and reads in flight
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h3, 1, 16'h4000 + 16'(i), 3'(i + 1));
      step();
    end
    chk("pre_rst_valid", 32'(oPixelValid), 1);
    chk("pre_rst_color", 32'(oPixelColor), 3);
    #2;
    Reset = 1'b0;
    drive(0, 16'h0, 0, 16'h0, 3'd0);
    #1;
    chk("arst_valid", 32'(oPixelValid), 0);
    chk("arst_color", 32'(oPixelColor), 0);
    chk("arst_addr", 32'(oRamAddr), 0);
    chk("arst_wren", 32'(oRamWrEn), 0);
    chk("arst_wdata", 32'(oRamWrData), 0);
    chk("arst_ovf", 32'(oWrOverflow), 0);
    chk("arst_full", 32'(oWrFull), 0);
    step();
    step();
    Reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("post_rst%0d_wren", i),
          32'(oRamWrEn), 0);
      chk($sformatf("post_rst%0d_valid", i),
          32'(oPixelValid), 0);
    end

    // overflow: five writes while reads hog the RAM
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'h0, 1, 16'h0100 + 16'(i), 3'(i + 1));
      #1;
      chk($sformatf("ovf_ack%0d", i), 32'(oWrAck), 1);
      step();
      chk($sformatf("ovf_wren%0d", i), 32'(oRamWrEn), 0);
    end
    chk("ovf_full", 32'(oWrFull), 1);
    chk("ovf_pre", 32'(oWrOverflow), 0);
    drive(1, 16'h0, 1, 16'h0104, 3'd6);
    #1;
    chk("ovf_ack4", 32'(oWrAck), 0);
    step();
    chk("ovf_set", 32'(oWrOverflow), 1);
    chk("ovf_wren4", 32'(oRamWrEn), 0);
    drive(0, 16'h0, 0, 16'h0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_wr($sformatf("drain_w%0d", i),
             16'h0100 + 16'(i), 3'(i + 1));
    end
    step();
    chk("drain_idle", 32'(oRamWrEn), 0);
    chk("drain_ovf", 32'(oWrOverflow), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
Shares the single-port 65536 x 3-bit video RAM between the VGA scan-out reader and a CPU/drawing-engine writer.
- Pixel reads from the VGA controller always have priority and a fixed latency.
- CPU writes are buffered in a small FIFO and drained into RAM cycles where no pixel read is requested (blanking, border, or any cycle with iPixelReq low).
- Sits between VGA_Controller (oReadAddress/wColorFromVideoMemory) and the video RAM.

Parameters:
ADDR_W, 16, video RAM address width (256x256 frame)
COLOR_W, 3, pixel width {R,G,B}
WFIFO_DEPTH, 4, write FIFO entries (power of two, >=2)

Ports:
Clock  in  1  system clock; all logic on posedge
Reset  in  1  asynchronous, active-low reset
iPixelReq  in  1  VGA needs a pixel read this cycle
iPixelAddr  in  ADDR_W  pixel read address
oPixelColor  out  COLOR_W  read data returned to VGA
oPixelValid  out  1  oPixelColor valid this cycle
iWrReq  in  1  CPU write request
iWrAddr  in  ADDR_W  CPU write address
iWrData  in  COLOR_W  CPU write colour
oWrAck  out  1  write accepted into FIFO this cycle (combinational: iWrReq & !full)
oWrFull  out  1  FIFO full
oWrOverflow  out  1  sticky: iWrReq seen while full (write dropped)
oRamAddr  out  ADDR_W  registered RAM address
oRamWrEn  out  1  registered RAM write enable
oRamWrData  out  COLOR_W  registered RAM write data
iRamRdData  in  COLOR_W  RAM read data, valid the cycle after RAM samples oRamAddr

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs 0: oPixelColor=0, oPixelValid=0, oRamAddr=0, oRamWrEn=0, oRamWrData=0, oWrOverflow=0.
  - FIFO emptied; grant state SLOT_IDLE.
  - Asserting Reset mid-operation discards queued writes and any in-flight read; no oPixelValid for it.
- Slot grant, evaluated every edge with registered state SLOT_IDLE/SLOT_RD/SLOT_WR:
  - iPixelReq=1 -> SLOT_RD: oRamAddr<=iPixelAddr, oRamWrEn<=0.
  - else FIFO non-empty -> SLOT_WR: pop head; oRamAddr<=head.addr, oRamWrData<=head.data, oRamWrEn<=1.
  - else SLOT_IDLE: oRamWrEn<=0, oRamAddr holds.
- Read latency: iPixelReq sampled at edge k -> RAM samples address at k+1 -> oPixelColor<=iRamRdData at k+2, oPixelValid=1 for the cycle after k+2. Fixed at 2 cycles and pipelined; back-to-back requests give back-to-back valids.
- Read-valid pipeline: a 2-stage shift register of SLOT_RD flags drives oPixelValid. oPixelColor holds its last value when not valid.
- Write FIFO:
  - Push on iWrReq & !full. Pop only in an SLOT_WR grant.
  - Read/write pointers are log2(WFIFO_DEPTH) bits and wrap modulo depth; count is log2+1 bits.
  - Full and empty are decoded from count.
- FIFO boundary conditions:
  - Push and pop in the same cycle with FIFO full: the push is refused (full is evaluated before the pop), oWrAck=0, oWrOverflow sets.
  - Push and pop in the same cycle, not full: count unchanged.
  - Push into an empty FIFO: no bypass; the earliest RAM write is the cycle after the push.
- Ordering:
  - Writes reach RAM in acceptance order.
  - A pixel read to an address with a pending FIFO write returns old RAM data. There is no forwarding; the frame is allowed to tear.
- Starvation: if iPixelReq stays high continuously, writes wait indefinitely. oWrFull back-pressures the CPU, which must hold iWrReq until oWrAck.
- oWrOverflow clears only on Reset.

Decomposition:
- Shared package vga_pkg:
  - ADDR_W, COLOR_W, RES_H=256, RES_V=256 constants.
  - Slot-state enum {SLOT_IDLE, SLOT_RD, SLOT_WR}.
  - Packed write-entry typedef {addr, data}.
- Sub-module vram_write_fifo: parameterised synchronous FIFO with push/pop/full/empty/count, reset async active-low.
- Arbiter top holds the grant FSM, the RAM output registers and the read-valid pipeline.

Test Plan:
- Reset released, iPixelReq=1, addr 0x0000..0x0003 on consecutive cycles, RAM model preloaded with addr[2:0] -> oPixelValid high 2 cycles after each request, colours 0,1,2,3 in order, oRamWrEn never 1.
- iPixelReq=0, write (0x1234, 3'b101) -> oWrAck same cycle; next cycle oRamWrEn=1, oRamAddr=0x1234, oRamWrData=5; FIFO empty afterwards.
- iPixelReq held 1, 5 writes issued -> first 4 acked, oWrFull=1, 5th not acked and oWrOverflow=1; drop iPixelReq -> 4 RAM writes on 4 consecutive cycles in acceptance order.
- FIFO full with iPixelReq=0 and iWrReq=1 the same cycle -> pop occurs, push refused, count 4->3, oWrOverflow=1.
- Interleave: iPixelReq pattern 1,0,1,0 with 2 queued writes -> writes occupy only the iPixelReq=0 cycles, read valids unaffected in latency.
- Reset asserted asynchronously mid-burst with 3 queued writes and 2 reads in flight -> all outputs 0 immediately; after release, no RAM writes and no oPixelValid without new requests.
